// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the two-digit seven-segment scan controller.
// Holds the segment codes (active-low, dp off), the FSM state type,
// the display range limit and the double-dabble nibble adjust helper.
package seg_scan_ctrl_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  localparam int MAX_DISPLAY = 99;
  localparam int CONV_STEPS  = 7;   // one shift per bit of the 7-bit input

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_COMMIT
  } state_t;

  // Shift-add-3 correction applied to each BCD nibble before a shift.
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_digit_enc.sv
// seg_digit_enc: combinational BCD digit to active-low segment code.
//   i_bcd   [3:0]  BCD digit 0..9 (other codes render blank)
//   i_blank        force the blank code regardless of i_bcd
//   o_seg   [7:0]  active-low segments, bit7=dp (off), bits6..0 = g..a
module seg_digit_enc
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] i_bcd,
  input  logic       i_blank,
  output logic [7:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank) begin
      unique case (i_bcd)
        4'd0:    o_seg = SEG_0;
        4'd1:    o_seg = SEG_1;
        4'd2:    o_seg = SEG_2;
        4'd3:    o_seg = SEG_3;
        4'd4:    o_seg = SEG_4;
        4'd5:    o_seg = SEG_5;
        4'd6:    o_seg = SEG_6;
        4'd7:    o_seg = SEG_7;
        4'd8:    o_seg = SEG_8;
        4'd9:    o_seg = SEG_9;
        default: o_seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: two-digit multiplexed seven-segment display controller.
// A load captures a 7-bit binary value, a 7-cycle shift-add-3 engine turns
// it into two BCD digits, and a COMMIT cycle writes the display registers.
// A free-running refresh counter alternates the units and tens digits on
// the shared segment bus.
//   clk, rst_n   clock, async active-low reset
//   value [6:0]  binary value to display
//   load         capture request, honoured only while busy=0
//   busy         conversion in progress
//   done         one-cycle pulse when new digits are committed
//   ovf          displayed value was >99 (held until next accepted load)
//   seg   [7:0]  active-low segment bus (bit7 = dp, always off)
//   an    [1:0]  active-low digit enables, an[0]=units, an[1]=tens
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] value,
  input  logic       load,
  output logic       busy,
  output logic       done,
  output logic       ovf,
  output logic [7:0] seg,
  output logic [1:0] an
);

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [2:0]       ITER_LAST = 3'(CONV_STEPS - 1);

  state_t       r_state;
  logic [6:0]   r_shift;
  logic [7:0]   r_bcd;
  logic [2:0]   r_iter;
  logic         r_big;      // captured value exceeds the two-digit range
  logic         r_busy;
  logic         r_done;
  logic         r_ovf;
  logic [7:0]   r_units;
  logic [7:0]   r_tens;

  logic [CNT_W-1:0] r_rcnt;
  logic             r_sel;  // 0 = units, 1 = tens
  logic [7:0]       r_seg;
  logic [1:0]       r_an;

  logic [7:0] w_units_code;
  logic [7:0] w_tens_code;

  // Encoders see the finished BCD value during COMMIT.
  seg_digit_enc u_enc_units (
    .i_bcd   (r_bcd[3:0]),
    .i_blank (1'b0),
    .o_seg   (w_units_code)
  );

  // Leading-zero suppression on the tens digit.
  seg_digit_enc u_enc_tens (
    .i_bcd   (r_bcd[7:4]),
    .i_blank (r_bcd[7:4] == 4'd0),
    .o_seg   (w_tens_code)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_bcd   <= '0;
      r_iter  <= '0;
      r_big   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_units <= SEG_BLANK;
      r_tens  <= SEG_BLANK;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (load) begin
            r_shift <= value;
            r_bcd   <= '0;
            r_iter  <= '0;
            r_big   <= (value > 7'(MAX_DISPLAY));
            r_ovf   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_CONV;
          end
        end
        S_CONV: begin
          // Hundreds carry out of the tens nibble is dropped: range is
          // decided by r_big, not by the BCD result.
          r_bcd   <= 8'({add3(r_bcd[7:4]), add3(r_bcd[3:0]), r_shift[6]});
          r_shift <= r_shift << 1;
          r_iter  <= r_iter + 3'd1;
          if (r_iter == ITER_LAST) r_state <= S_COMMIT;
        end
        S_COMMIT: begin
          if (r_big) begin
            r_units <= SEG_DASH;
            r_tens  <= SEG_DASH;
            r_ovf   <= 1'b1;
          end else begin
            r_units <= w_units_code;
            r_tens  <= w_tens_code;
            r_ovf   <= 1'b0;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Scan path runs independently of the converter; an and seg are loaded
  // on the same edge so the bus never shows one digit's code on the other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rcnt <= '0;
      r_sel  <= 1'b0;
      r_seg  <= SEG_BLANK;
      r_an   <= 2'b10;
    end else begin
      if (r_rcnt == DIV_LAST) begin
        r_rcnt <= '0;
        r_sel  <= ~r_sel;
      end else begin
        r_rcnt <= r_rcnt + 1'b1;
      end
      r_an  <= r_sel ? 2'b01  : 2'b10;
      r_seg <= r_sel ? r_tens : r_units;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign ovf  = r_ovf;
  assign seg  = r_seg;
  assign an   = r_an;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed testbench for seg_scan_ctrl with a small decimal reference model.
module tb_seg_scan_ctrl;

  localparam int RD = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       load  = 1'b0;
  logic [6:0] value = '0;
  logic       busy, done, ovf;
  logic [7:0] seg;
  logic [1:0] an;

  int errs   = 0;
  int checks = 0;
  int an_bad = 0;

  seg_scan_ctrl #(.REFRESH_DIV(RD), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .value (value),
    .load  (load),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf),
    .seg   (seg),
    .an    (an)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && an == 2'b00) an_bad++;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] code(input int d);
    case (d)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] exp_units(input int v);
    return (v > 99) ? 8'hBF : code(v % 10);
  endfunction

  function automatic logic [7:0] exp_tens(input int v);
    if (v > 99) return 8'hBF;
    return (v / 10 == 0) ? 8'hFF : code(v / 10);
  endfunction

  // Called at a negedge; returns at the negedge where done is high.
  task automatic do_load(input logic [6:0] v);
    int nb  = 0;
    bit got = 0;
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin got = 1; break; end
      if (busy) nb++;
      @(negedge clk);
    end
    chk("done_seen", 32'(got), 32'd1);
    chk("busy_cycles", 32'(nb), 32'd8);
    chk("busy_at_done", 32'(busy), 32'd0);
  endtask

  task automatic get_digits(output logic [7:0] u, output logic [7:0] t);
    bit su = 0, st = 0;
    u = 'x; t = 'x;
    @(negedge clk);
    for (int i = 0; i < 4 * RD; i++) begin
      if (an == 2'b10) begin u = seg; su = 1; end
      else if (an == 2'b01) begin t = seg; st = 1; end
      if (su && st) break;
      @(negedge clk);
    end
    if (!(su && st)) chk("scan_timeout", 32'd0, 32'd1);
  endtask

  task automatic verify(input int v, input string tag);
    logic [7:0] u, t;
    get_digits(u, t);
    chk({tag, "_units"}, 32'(u), 32'(exp_units(v)));
    chk({tag, "_tens"},  32'(t), 32'(exp_tens(v)));
    chk({tag, "_ovf"},   32'(ovf), 32'(v > 99));
  endtask

  initial begin
    logic [1:0] a0;
    int n, ndone;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_seg",  32'(seg),  32'hFF);
    chk("rst_an",   32'(an),   32'h2);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf",  32'(ovf),  32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 47 and scan hold length
    do_load(7'd47);
    verify(47, "v47");
    a0 = an;
    n  = 0;
    while (an == a0 && n < 20) begin n++; @(negedge clk); end
    a0 = an;
    n  = 0;
    while (an == a0 && n < 20) begin n++; @(negedge clk); end
    chk("hold_len", 32'(n), 32'(RD));

    do_load(7'd5);   verify(5, "v5");
    do_load(7'd0);   verify(0, "v0");
    do_load(7'd99);  verify(99, "v99");
    do_load(7'd100); verify(100, "v100");
    do_load(7'd12);  verify(12, "v12");

    // load while busy is ignored, value changes after capture ignored
    value = 7'd63; load = 1'b1;
    @(negedge clk); load = 1'b0;
    @(negedge clk);
    value = 7'd21; load = 1'b1;
    @(negedge clk); load = 1'b0;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("busy_ignore_done_cnt", 32'(ndone), 32'd1);
    verify(63, "v63");

    // back-to-back: second load issued in the done cycle
    do_load(7'd12);
    do_load(7'd34);
    verify(34, "v34");

    // reset mid-conversion with ovf set
    do_load(7'd127); verify(127, "v127");
    value = 7'd55; load = 1'b1;
    @(negedge clk); load = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_seg",  32'(seg),  32'hFF);
    chk("mid_rst_an",   32'(an),   32'h2);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_ovf",  32'(ovf),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      if (done || busy) ndone++;
      @(negedge clk);
    end
    chk("mid_rst_no_done", 32'(ndone), 32'd0);

    // full sweep against the decimal model
    for (int v = 0; v < 128; v++) begin
      do_load(7'(v));
      verify(v, $sformatf("sweep%0d", v));
    end

    chk("an_never_00", 32'(an_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
